// File: rtl/fma_pkg.sv
// Shared constants and inter-stage payloads for the FMA normalize/round/pack stage.
package fma_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int FRAC_W   = 23;

  localparam int FLG_OVF  = 3;
  localparam int FLG_UNF  = 2;
  localparam int FLG_INX  = 1;
  localparam int FLG_ZERO = 0;

  // Payload widths; the top-level parameters default to these.
  localparam int NEXP_W  = 10;
  localparam int NMANT_W = 48;

  typedef struct packed {
    logic                      sign;
    logic signed [NEXP_W-1:0]  exp;
    logic [NMANT_W-1:0]        mant;
    logic [5:0]                lzc;
  } s1_t;

  typedef struct packed {
    logic                      sign;
    logic                      zero;
    logic signed [NEXP_W:0]    exp;
    logic [NMANT_W-1:0]        norm;
  } s2_t;
endpackage

// File: rtl/lzc48.sv
// Combinational 48-bit leading-zero counter; an all-zero input yields 48.
module lzc48 (
  input  logic [47:0] val,
  output logic [5:0]  cnt
);
  always_comb begin
    cnt = 6'd48;
    // Ascending scan: the highest set bit is the last one to write cnt.
    for (int i = 0; i < 48; i++)
      if (val[i]) cnt = 6'(47 - i);
  end
endmodule

// File: rtl/fma_norm_round.sv
// Three-stage normalize / RNE round / binary32 pack behind the significand multiplier.
module fma_norm_round
  import fma_pkg::*;
#(
  parameter int EXP_W  = NEXP_W,
  parameter int MANT_W = NMANT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [MANT_W-1:0]       in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic [3:0]              out_flags
);
  localparam int STAGES = 3;

  logic              adv;
  logic [STAGES:1]   vld_pipe;
  logic [5:0]        lzc;
  s1_t               s1;
  s2_t               s2;

  assign adv       = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  lzc48 u_lzc (.val(in_mant), .cnt(lzc));

  // Stages shift in lockstep; bubbles are carried, not squeezed out.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1.sign <= in_sign;
      s1.exp  <= in_exp;
      s1.mant <= in_mant;
      s1.lzc  <= lzc;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s2.sign <= s1.sign;
      s2.zero <= (s1.mant == '0);
      s2.norm <= s1.mant << s1.lzc;
      s2.exp  <= $signed({s1.exp[EXP_W-1], s1.exp}) + (EXP_W+1)'(1)
               - $signed({(EXP_W+1-6)'(0), s1.lzc});
    end
  end

  logic [FRAC_W-1:0]      frac, frac_r;
  logic                   guard, sticky, rnd, carry;
  logic signed [EXP_W:0]  exp_r;
  logic [31:0]            res_nxt;
  logic [3:0]             flg_nxt;

  always_comb begin
    frac   = s2.norm[46:24];
    guard  = s2.norm[23];
    sticky = |s2.norm[22:0];
    rnd    = guard && (sticky || frac[0]);
    {carry, frac_r} = {1'b0, frac} + (FRAC_W+1)'(rnd);
    // Rounding 1.111..1 up gives 10.0: fraction wraps to zero, exponent bumps.
    exp_r  = carry ? s2.exp + (EXP_W+1)'(1) : s2.exp;

    res_nxt = '0;
    flg_nxt = '0;
    if (s2.zero) begin
      res_nxt = {s2.sign, 31'h0};
      flg_nxt[FLG_ZERO] = 1'b1;
    end else if (exp_r >= (EXP_W+1)'(EXP_MAX)) begin
      res_nxt = {s2.sign, 8'hFF, 23'h0};
      flg_nxt[FLG_OVF] = 1'b1;
      flg_nxt[FLG_INX] = 1'b1;
    end else if (exp_r <= (EXP_W+1)'(0)) begin
      res_nxt = {s2.sign, 31'h0};
      flg_nxt[FLG_UNF]  = 1'b1;
      flg_nxt[FLG_INX]  = 1'b1;
      flg_nxt[FLG_ZERO] = 1'b1;
    end else begin
      res_nxt = {s2.sign, exp_r[7:0], frac_r};
      flg_nxt[FLG_INX] = guard | sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_result <= '0;
      out_flags  <= '0;
    end else if (adv) begin
      out_result <= res_nxt;
      out_flags  <= flg_nxt;
    end
  end
endmodule
